data_ram_resp: RTL and testbench
================================

// Module: data_ram_resp
// PURPOSE
//  Data-memory responder on the far end of the MEM-stage bus (ce/we/addr/sel/data).
//  Holds a single-port word array and posts stores into a one-entry store buffer, so
//  stores never stall. Loads take 2 cycles and raise stallreq_o for the first one.
//  Loads that hit a buffered store get that store's bytes forwarded.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; array depth = 2**ADDR_WIDTH words
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  ce_i        in   1   request valid
//  we_i        in   1   1 = store, 0 = load
//  addr_i      in   32  byte address; only [ADDR_WIDTH+1:2] used (upper bits wrap)
//  sel_i       in   4   byte-lane enables; sel[3] = data[31:24] (big-endian lane 0)
//  data_i      in   32  store data, already lane-replicated by requester
//  data_o      out  32  load data, valid only in RDATA state
//  stallreq_o  out  1   pipeline stall request
// BEHAVIOUR
//  Reset (async, rst=1), effective immediately:
//   - state=IDLE, data_o=0, stallreq_o=0, buffer valid=0.
//   - A pending posted store is discarded. Array contents are not reset.
//  FSM states: IDLE, RDATA.
//   - IDLE, ce_i=1, we_i=0 (load):
//     - stallreq_o=1 (combinational).
//     - Array read of word addr_i[ADDR_WIDTH+1:2] issued at the edge; -> RDATA.
//     - Store buffer holds its entry; the port is busy this edge.
//   - IDLE, ce_i=1, we_i=1 (store):
//     - No stall.
//     - If buffer valid, drain it to the array at this edge (port free).
//     - Load {word addr, sel_i, data_i} into the buffer at the same edge.
//     - If sel_i=0, the buffer is cleared instead of loaded.
//   - IDLE, ce_i=0:
//     - Buffer drains if valid; stay IDLE.
//   - RDATA (unconditionally -> IDLE next edge):
//     - stallreq_o=0. The requester holds inputs stable, so the load is not re-issued.
//     - data_o = array word merged with buffer bytes: per lane k, take the buffer byte
//       if buffer valid && buffer addr == latched load addr && buffer sel[k]=1.
//     - Buffer drains at the end of RDATA (port free).
//  Outside RDATA, data_o=0.
//  Load latency: request cycle + 1. Store throughput: 1 per cycle, never stalls.
//  Array write: byte-masked by the buffered sel; unselected lanes keep old bytes.
//  Boundary cases:
//   - Store then immediate load, same word: load returns merged data (forwarding);
//     the array is written afterwards.
//   - Back-to-back stores, same word: the first drains while the second loads;
//     final content = second over first.
//   - Load then store: the store is seen in IDLE after RDATA, then handled normally.
//   - rst asserted during RDATA: data_o and stallreq_o go to 0 at once; FSM -> IDLE.
//   - Addresses differing only above bit ADDR_WIDTH+1 alias to the same word.
// TESTING
//  1. rst pulse mid-RDATA -> data_o=0, stallreq_o=0 immediately.
//     A load from a word previously written then returns the old array value
//     (buffered store lost).
//  2. SW 0x1234_5678 @0x10, sel=1111; next cycle LW @0x10
//     -> stallreq_o=1 for 1 cycle, then data_o=0x1234_5678 (forwarded).
//  3. SW 0xAABB_CCDD @0x20; SB 0x11 replicated, sel=0100 @0x21; idle 2 cycles;
//     LW @0x20 -> data_o=0xAA11_CCDD.
//  4. SH 0xBEEF replicated, sel=0011 @0x32 over existing 0x0000_0000;
//     immediate LW @0x30 -> data_o=0x0000_BEEF.
//  5. Alternating LW/SW stream for 20 cycles vs reference model
//     -> every load matches, and stallreq_o is high exactly 1 cycle per load.
//  6. SW with sel=0000 @0x40 (word 0x40 was 0xCAFE_0001)
//     -> LW @0x40 returns 0xCAFE_0001 unchanged.

Source files
------------

// File: rtl/data_ram_resp_if.sv
// data_ram_resp_if: MEM-stage data bus between the requester and the data RAM responder
interface data_ram_resp_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stallreq_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, stallreq_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, stallreq_o
    );
endinterface

// File: rtl/data_ram_resp.sv
// data_ram_resp: single-port data RAM with a posted one-entry store buffer and 2-cycle loads
module data_ram_resp #(
    parameter int ADDR_WIDTH = 10
) (
    input logic            clk,
    input logic            rst,
    data_ram_resp_if.slave bus
);
    typedef enum logic {IDLE, RDATA} state_t;
    state_t                state, state_nxt;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word_addr, ld_addr, buf_addr;
    logic [3:0]            buf_sel;
    logic [31:0]           buf_data, rd_word, merged;
    logic                  buf_valid, is_load, is_store, drain, fill, unused_addr;

    assign word_addr   = bus.addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};
    assign is_load     = state == IDLE && bus.ce_i && !bus.we_i;
    assign is_store    = state == IDLE && bus.ce_i && bus.we_i;
    // The port is only busy on the load-issue edge; every other edge may retire the buffer.
    assign drain       = buf_valid && !is_load;
    assign fill        = is_store && |bus.sel_i;

    // Next state, buffer-forwarding merge of the read word, and outputs.
    always_comb begin
        state_nxt = is_load ? RDATA : IDLE;
        merged    = rd_word;
        for (int k = 0; k < 4; k++)
            if (buf_valid && buf_addr == ld_addr && buf_sel[k])
                merged[8*k +: 8] = buf_data[8*k +: 8];
        bus.data_o     = state == RDATA ? merged : '0;
        bus.stallreq_o = is_load && !rst;
    end

    // FSM state and buffer occupancy; reset throws away any posted store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!is_load)
                buf_valid <= fill;
        end
    end

    // Array port (drain write or load read), load address latch and buffer payload.
    always_ff @(posedge clk) begin
        if (drain)
            for (int k = 0; k < 4; k++)
                if (buf_sel[k])
                    mem[buf_addr][8*k +: 8] <= buf_data[8*k +: 8];
        if (is_load) begin
            rd_word <= mem[word_addr];
            ld_addr <= word_addr;
        end
        if (fill) begin
            buf_addr <= word_addr;
            buf_sel  <= bus.sel_i;
            buf_data <= bus.data_i;
        end
    end
endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: table-driven and scoreboard checks of the data RAM responder
module tb_data_ram_resp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_ram_resp_if bus ();
    data_ram_resp #(.ADDR_WIDTH(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef enum {OP_IDLE, OP_ST, OP_LD} op_t;
    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    vec_t        vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return model.exists(int'(a[11:2])) ? model[int'(a[11:2])] : 32'h0;
    endfunction

    task automatic do_idle();
        bus.ce_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] w;
        w = mdl_rd(a);
        for (int k = 0; k < 4; k++)
            if (s[k]) w[8*k +: 8] = d[8*k +: 8];
        model[int'(a[11:2])] = w;
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.sel_i = s; bus.data_i = d;
        #1 check("st_stall", 32'(bus.stallreq_o), 32'h0);
        @(posedge clk); #1;
        bus.ce_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.sel_i = 4'hF;
        #1 check("ld_req_stall", 32'(bus.stallreq_o), 32'h1);
        @(posedge clk); #1;
        check("ld_rdata_stall", 32'(bus.stallreq_o), 32'h0);
        check("ld_data", bus.data_o, exp_q.pop_front());
        @(posedge clk); #1;
        bus.ce_i = 1'b0;
        check("ld_after_data", bus.data_o, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = '0; bus.sel_i = '0; bus.data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", bus.data_o, 32'h0);
        check("rst_stall", 32'(bus.stallreq_o), 32'h0);
        bus.ce_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        vecs.push_back('{OP_ST, 32'h10, 4'b1111, 32'h1234_5678, 32'h0});
        vecs.push_back('{OP_LD, 32'h10, 4'b1111, 32'h0, 32'h1234_5678});
        vecs.push_back('{OP_ST, 32'h20, 4'b1111, 32'hAABB_CCDD, 32'h0});
        vecs.push_back('{OP_ST, 32'h21, 4'b0100, 32'h1111_1111, 32'h0});
        vecs.push_back('{OP_IDLE, 32'h0, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{OP_IDLE, 32'h0, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{OP_LD, 32'h20, 4'b1111, 32'h0, 32'hAA11_CCDD});
        vecs.push_back('{OP_ST, 32'h30, 4'b1111, 32'h0000_0000, 32'h0});
        vecs.push_back('{OP_ST, 32'h32, 4'b0011, 32'hBEEF_BEEF, 32'h0});
        vecs.push_back('{OP_LD, 32'h30, 4'b1111, 32'h0, 32'h0000_BEEF});
        vecs.push_back('{OP_ST, 32'h40, 4'b1111, 32'hCAFE_0001, 32'h0});
        vecs.push_back('{OP_IDLE, 32'h0, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{OP_ST, 32'h40, 4'b0000, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{OP_LD, 32'h40, 4'b1111, 32'h0, 32'hCAFE_0001});
        vecs.push_back('{OP_ST, 32'h60, 4'b1111, 32'h1122_3344, 32'h0});
        vecs.push_back('{OP_ST, 32'h60, 4'b0101, 32'h5566_7788, 32'h0});
        vecs.push_back('{OP_IDLE, 32'h0, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{OP_LD, 32'h60, 4'b1111, 32'h0, 32'h1166_3388});
        vecs.push_back('{OP_ST, 32'h1010, 4'b1111, 32'h89AB_CDEF, 32'h0});
        vecs.push_back('{OP_LD, 32'h10, 4'b1111, 32'h0, 32'h89AB_CDEF});
        foreach (vecs[i])
            case (vecs[i].op)
                OP_ST:   do_store(vecs[i].addr, vecs[i].sel, vecs[i].data);
                OP_LD:   do_load(vecs[i].addr, vecs[i].exp);
                default: do_idle();
            endcase

        do_store(32'h50, 4'b1111, 32'h5555_AAAA);
        do_idle();
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h50; bus.sel_i = 4'b1111; bus.data_i = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        bus.we_i = 1'b0;
        #1 check("rst_case_stall", 32'(bus.stallreq_o), 32'h1);
        @(posedge clk); #1;
        check("rst_case_fwd", bus.data_o, 32'h0BAD_0BAD);
        rst = 1'b1;
        #1 check("mid_rdata_rst_data", bus.data_o, 32'h0);
        check("mid_rdata_rst_stall", 32'(bus.stallreq_o), 32'h0);
        #1 rst = 1'b0;
        bus.ce_i = 1'b0;
        @(posedge clk); #1;
        do_load(32'h50, 32'h5555_AAAA);

        for (int w = 0; w < 8; w++)
            do_store(32'h400 + 32'(4 * w), 4'b1111, $urandom);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            a = 32'h400 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if (i % 2 == 0)
                do_load(a, mdl_rd(a));
            else
                do_store(a, 4'($urandom_range(0, 15)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
